// File: rtl/vc_sram_req_adapter_pkg.sv
// Shared constants and helpers for the SRAM request adapter and its response queue.
package vc_sram_req_adapter_pkg;

  localparam logic VC_MEM_REQ_READ  = 1'b0;
  localparam logic VC_MEM_REQ_WRITE = 1'b1;

  localparam int unsigned c_resp_q_depth = 3;

  // Queue pointers step 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_incr(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/vc_sram_req_adapter_resp_queue.sv
// Three-entry circular response buffer with val/rdy on both sides and an exported occupancy count.
module vc_sram_resp_queue
  import vc_sram_req_adapter_pkg::*;
#(
  parameter int unsigned p_width = 33
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_val_i,
  output logic               enq_rdy_o,
  input  logic [p_width-1:0] enq_data_i,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_width-1:0] deq_data_o,
  output logic [1:0]         count_o
);

  logic [p_width-1:0] buf_q [c_resp_q_depth];
  logic [1:0] enq_ptr_q, enq_ptr_d;
  logic [1:0] deq_ptr_q, deq_ptr_d;
  logic [1:0] count_q, count_d;
  logic       enq_fire;
  logic       deq_fire;

  assign enq_rdy_o  = (count_q != 2'd3);
  assign deq_val_o  = (count_q != 2'd0);
  assign deq_data_o = buf_q[deq_ptr_q];
  assign count_o    = count_q;

  assign enq_fire = enq_val_i && enq_rdy_o;
  assign deq_fire = deq_val_o && deq_rdy_i;

  always_comb begin
    enq_ptr_d = enq_fire ? ptr_incr(enq_ptr_q) : enq_ptr_q;
    deq_ptr_d = deq_fire ? ptr_incr(deq_ptr_q) : deq_ptr_q;
    count_d   = count_q;
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enq_ptr_q <= 2'd0;
      deq_ptr_q <= 2'd0;
      count_q   <= 2'd0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Payload storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      buf_q[enq_ptr_q] <= enq_data_i;
    end
  end

endmodule

// File: rtl/vc_sram_req_adapter.sv
// Val/rdy front end for a 1rw synchronous SRAM: drives the SRAM pins on request fire,
// captures 1-cycle read data and returns in-order responses through a 3-entry queue.
module vc_sram_req_adapter
  import vc_sram_req_adapter_pkg::*;
#(
  parameter  int unsigned p_data_nbits  = 32,
  parameter  int unsigned p_num_entries = 256,
  localparam int unsigned c_addr_nbits  = $clog2(p_num_entries),
  localparam int unsigned c_data_nbytes = (p_data_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_type,
  input  logic [c_addr_nbits-1:0]  req_addr,
  input  logic [p_data_nbits-1:0]  req_data,
  input  logic [c_data_nbytes-1:0] req_byte_en,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic                     resp_type,
  output logic [p_data_nbits-1:0]  resp_data,
  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data
);

  logic                  s1_val_q, s1_val_d;
  logic                  s1_type_q, s1_type_d;
  logic                  req_fire;
  logic [2:0]            inflight;
  logic                  q_enq_rdy;
  logic [1:0]            q_count;
  logic [p_data_nbits:0] q_enq_data;
  logic [p_data_nbits:0] q_deq_data;

  // Every accepted request owns a queue slot until it is dequeued, so the queue
  // can never overflow and resp_rdy never reaches req_rdy combinationally.
  assign inflight = {2'b00, s1_val_q} + {1'b0, q_count};
  assign req_rdy  = !reset && (inflight < 3'(c_resp_q_depth));
  assign req_fire = req_val && req_rdy;

  assign sram_read_en       = req_fire && (req_type == VC_MEM_REQ_READ);
  assign sram_write_en      = req_fire && (req_type == VC_MEM_REQ_WRITE);
  assign sram_read_addr     = req_addr;
  assign sram_write_addr    = req_addr;
  assign sram_write_data    = req_data;
  assign sram_write_byte_en = req_byte_en;

  always_comb begin
    s1_val_d  = req_fire;
    s1_type_d = req_fire ? req_type : s1_type_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val_q  <= 1'b0;
      s1_type_q <= VC_MEM_REQ_READ;
    end else begin
      s1_val_q  <= s1_val_d;
      s1_type_q <= s1_type_d;
    end
  end

  assign q_enq_data = {s1_type_q,
                       (s1_type_q == VC_MEM_REQ_WRITE) ? '0 : sram_read_data};

  vc_sram_resp_queue #(
    .p_width (p_data_nbits + 1)
  ) u_resp_q (
    .clk_i      (clk),
    .reset_i    (reset),
    .enq_val_i  (s1_val_q),
    .enq_rdy_o  (q_enq_rdy),
    .enq_data_i (q_enq_data),
    .deq_val_o  (resp_val),
    .deq_rdy_i  (resp_rdy),
    .deq_data_o (q_deq_data),
    .count_o    (q_count)
  );

  assign resp_type = q_deq_data[p_data_nbits];
  assign resp_data = q_deq_data[p_data_nbits-1:0];

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (reset)
    !(s1_val_q && !q_enq_rdy));
  a_req_val_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(req_val));
  a_resp_rdy_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(resp_rdy));
  a_addr_in_range: assert property (@(posedge clk) disable iff (reset)
    req_fire |-> ({1'b0, req_addr} < (c_addr_nbits + 1)'(p_num_entries)));
  a_byte_en_known: assert property (@(posedge clk) disable iff (reset)
    (req_fire && req_type == VC_MEM_REQ_WRITE) |-> !$isunknown(req_byte_en));

endmodule

// File: tb/tb_vc_sram_req_adapter.sv
// Randomized and directed bench for vc_sram_req_adapter against a transaction-level
// model: outstanding-request credit, 2-cycle visibility, in-order responses, byte-masked memory.
module tb_vc_sram_req_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic        req_type = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_byte_en = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic        resp_type;
  logic [31:0] resp_data;
  logic        sram_read_en;
  logic [7:0]  sram_read_addr;
  logic [31:0] sram_read_data = '0;
  logic        sram_write_en;
  logic [3:0]  sram_write_byte_en;
  logic [7:0]  sram_write_addr;
  logic [31:0] sram_write_data;

  vc_sram_req_adapter #(
    .p_data_nbits  (32),
    .p_num_entries (256)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_val            (req_val),
    .req_rdy            (req_rdy),
    .req_type           (req_type),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .req_byte_en        (req_byte_en),
    .resp_val           (resp_val),
    .resp_rdy           (resp_rdy),
    .resp_type          (resp_type),
    .resp_data          (resp_data),
    .sram_read_en       (sram_read_en),
    .sram_read_addr     (sram_read_addr),
    .sram_read_data     (sram_read_data),
    .sram_write_en      (sram_write_en),
    .sram_write_byte_en (sram_write_byte_en),
    .sram_write_addr    (sram_write_addr),
    .sram_write_data    (sram_write_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SRAM environment: registered read, byte-masked write.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (sram_read_en) sram_read_data <= mem[sram_read_addr];
    if (sram_write_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
    end
  end

  // Reference model: memory contents plus an ordered list of outstanding requests.
  typedef struct {
    logic        t;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          fire_cnt = 0;
  int          resp_cnt = 0;
  logic        last_fire = 1'b0;
  logic [31:0] last_resp_data = '0;
  logic        m_rdy, m_fire, m_rv;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      last_fire = 1'b0;
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_val", resp_val, 0);
      chk("rst_rd_en", sram_read_en, 0);
      chk("rst_wr_en", sram_write_en, 0);
    end else begin
      m_rdy  = (exp_q.size() < 3);
      m_fire = req_val && m_rdy;
      m_rv   = (exp_q.size() > 0) && (exp_q[0].c + 2 <= cyc);
      chk("req_rdy", req_rdy, m_rdy);
      chk("rd_en", sram_read_en, m_fire && !req_type);
      chk("wr_en", sram_write_en, m_fire && req_type);
      chk("resp_val", resp_val, m_rv);
      if (m_fire && !req_type) chk("rd_addr", sram_read_addr, req_addr);
      if (m_fire && req_type) begin
        chk("wr_addr", sram_write_addr, req_addr);
        chk("wr_data", sram_write_data, req_data);
        chk("wr_be", sram_write_byte_en, req_byte_en);
      end
      if (m_rv && resp_val) begin
        chk("resp_type", resp_type, exp_q[0].t);
        chk("resp_data", resp_data, exp_q[0].d);
      end
      if (m_rv && resp_rdy) begin
        e = exp_q.pop_front();
        resp_cnt++;
        last_resp_data = resp_data;
        $display("resp %0d: cyc=%0d type=%0d data=%08h", resp_cnt, cyc, resp_type, resp_data);
      end
      if (m_fire) begin
        e.t = req_type;
        e.d = req_type ? 32'h0 : ref_mem[req_addr];
        e.c = cyc;
        exp_q.push_back(e);
        fire_cnt++;
        if (req_type) begin
          for (int b = 0; b < 4; b++)
            if (req_byte_en[b]) ref_mem[req_addr][8*b +: 8] = req_data[8*b +: 8];
        end
      end
      last_fire = m_fire;
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic t, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int k = 0;
    req_val = 1'b1; req_type = t; req_addr = a; req_data = d; req_byte_en = be;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!last_fire && k < 50);
    if (!last_fire) chk("send_timeout", 0, 1);
    req_val = 1'b0;
  endtask

  int f0, c0, k;
  logic [7:0] a;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    mem[3] = 32'hFFFFFFFF; ref_mem[3] = 32'hFFFFFFFF;

    step(3);
    reset = 1'b0;
    step(1);

    // Single read: latency and data.
    send(1'b0, 8'd5, 32'h0, 4'h0);
    step(3);
    chk("t1_read5", last_resp_data, 32'hDEADBEEF);

    // Partial write then read back.
    send(1'b1, 8'd3, 32'h11223344, 4'b0101);
    send(1'b0, 8'd3, 32'h0, 4'h0);
    step(4);
    chk("t2_read3", last_resp_data, 32'hFF22FF44);

    // Back-to-back reads at full throughput.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), 32'h0, 4'h0);
    chk("t3_cycles", cyc - c0, 8);
    step(4);

    // Backpressure: only three requests may be outstanding.
    resp_rdy = 1'b0;
    f0 = fire_cnt; a = 8'd10;
    req_val = 1'b1; req_type = 1'b0; req_addr = a;
    repeat (6) begin
      step(1);
      if (last_fire) begin a++; req_addr = a; end
    end
    chk("t4_accepted", fire_cnt - f0, 3);
    chk("t4_req_rdy", req_rdy, 0);
    resp_rdy = 1'b1;
    k = 0;
    while ((fire_cnt - f0) < 5 && k < 20) begin
      step(1);
      k++;
      if (last_fire) begin a++; req_addr = a; end
    end
    req_val = 1'b0;
    chk("t4_all_fired", fire_cnt - f0, 5);
    step(5);

    // Asynchronous reset with two queued and one in stage 1.
    resp_rdy = 1'b0;
    send(1'b0, 8'd20, 32'h0, 4'h0);
    send(1'b0, 8'd21, 32'h0, 4'h0);
    send(1'b0, 8'd22, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    chk("t5_resp_val", resp_val, 0);
    chk("t5_req_rdy", req_rdy, 0);
    step(2);
    reset = 1'b0;
    resp_rdy = 1'b1;
    step(3);
    chk("t5_resp_val_after", resp_val, 0);
    chk("t5_req_rdy_after", req_rdy, 1);

    // Write presented in the cycle reset asserts must not reach the SRAM.
    reset = 1'b1;
    req_val = 1'b1; req_type = 1'b1; req_addr = 8'd3; req_data = 32'h0; req_byte_en = 4'hF;
    #1;
    chk("t6_wr_en", sram_write_en, 0);
    step(1);
    reset = 1'b0;
    req_val = 1'b0;
    step(2);
    send(1'b0, 8'd3, 32'h0, 4'h0);
    step(4);
    chk("t6_read3", last_resp_data, 32'hFF22FF44);

    // Randomized traffic over a small address window to exercise read-after-write.
    repeat (400) begin
      req_val     = ($urandom_range(0, 3) != 0);
      req_type    = 1'($urandom_range(0, 1));
      req_addr    = 8'($urandom_range(0, 15));
      req_data    = $urandom;
      req_byte_en = 4'($urandom_range(0, 15));
      resp_rdy    = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_val = 1'b0;
    resp_rdy = 1'b1;
    step(8);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
